// File: rtl/sample_uart_tx.sv
// Multi-byte sample word serialiser onto an 8N1/8N2 async line with word FIFO and internal baud divider.
// Optional parity bit when SAMPLE_UART_TX_PARITY_EN is defined (adds parameter PARITY_ODD).
module sample_uart_tx #(
  parameter int          FREQ       = 100000000,
  parameter int          RATE       = 115200,
  parameter int          BYTES      = 4,
  parameter int          FIFO_DEPTH = 4,
  parameter int          STOP_BITS  = 1,
  parameter logic [31:0] ID_WORD    = 32'h534c4131
`ifdef SAMPLE_UART_TX_PARITY_EN
  , parameter bit        PARITY_ODD = 1'b0
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [8*BYTES-1:0] data,
  input  logic [BYTES-1:0]   disabledGroups,
  input  logic               write,
  input  logic               id,
  input  logic               xon,
  input  logic               xoff,
  output logic               tx,
  output logic               busy,
  output logic               full,
  output logic               overflow
);

  localparam int BITLENGTH = FREQ / RATE;
  localparam int DIVW      = (BITLENGTH > 1) ? $clog2(BITLENGTH) : 1;
`ifdef SAMPLE_UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FW        = 10 + STOP_BITS - 1 + PAR_BITS;
  localparam int BCW       = $clog2(FW);
  localparam int IDXW      = $clog2(BYTES + 1);
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int PW        = AW + 1;
  localparam int DW        = 8 * BYTES;
  localparam int EW        = DW + BYTES;

  localparam logic [DW-1:0]   ID_DATA  = DW'(ID_WORD);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BITLENGTH - 1);
  localparam logic [BCW-1:0]  BC_LAST  = BCW'(FW - 1);
  localparam logic [IDXW-1:0] IDX_END  = IDXW'(BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FRAME = 2'd2,
    S_NEXT  = 2'd3
  } state_t;

  state_t          state;
  logic [DW-1:0]   word_q;
  logic [BYTES-1:0] mask_q;
  logic [IDXW-1:0] idx;
  logic [FW-1:0]   shift_q;
  logic [FW-1:0]   frame_bits;
  logic [DIVW-1:0] div;
  logic [BCW-1:0]  bit_cnt;
  logic            paused;

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW-1:0]   wr_ptr_n, rd_ptr_n;
  logic            empty;
  logic            push_req, push_ok;
  logic [EW-1:0]   push_entry;
  logic            paused_n;
  logic            engine_idle_n;

  // write and id are single-cycle push strobes with no ready: a push while
  // full is dropped and recorded in the sticky overflow flag; write beats id.
  assign push_req   = write | id;
  assign push_ok    = push_req & ~full;
  assign push_entry = write ? {data, disabledGroups} : {ID_DATA, {BYTES{1'b0}}};

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign tx = shift_q[0];

`ifdef SAMPLE_UART_TX_PARITY_EN
  assign frame_bits = {{STOP_BITS{1'b1}}, ((^word_q[7:0]) ^ PARITY_ODD), word_q[7:0], 1'b0};
`else
  assign frame_bits = {{STOP_BITS{1'b1}}, word_q[7:0], 1'b0};
`endif

  // busy reflects the state the block is entering, so it drops on the same
  // edge the engine returns to IDLE.
  always_comb begin
    paused_n      = xon ? 1'b0 : (xoff ? 1'b1 : paused);
    wr_ptr_n      = wr_ptr + {{(PW-1){1'b0}}, push_ok};
    rd_ptr_n      = rd_ptr + {{(PW-1){1'b0}}, (state == S_LOAD)};
    engine_idle_n = ((state == S_IDLE) && (empty || paused)) ||
                    ((state == S_NEXT) && (idx == IDX_END));
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      word_q   <= '0;
      mask_q   <= '0;
      idx      <= '0;
      shift_q  <= '1;
      div      <= '0;
      bit_cnt  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      paused   <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      paused <= paused_n;
      busy   <= ~engine_idle_n | (wr_ptr_n != rd_ptr_n) | write | id | paused_n;
      if (push_req && full) overflow <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (!empty && !paused) state <= S_LOAD;
        end
        S_LOAD: begin
          {word_q, mask_q} <= mem[rd_ptr[AW-1:0]];
          idx              <= '0;
          state            <= S_NEXT;
        end
        S_NEXT: begin
          if (idx == IDX_END) begin
            state <= S_IDLE;
          end else if (mask_q[0]) begin
            idx    <= idx + 1'b1;
            word_q <= word_q >> 8;
            mask_q <= mask_q >> 1;
          end else if (!paused) begin
            shift_q <= frame_bits;
            div     <= '0;
            bit_cnt <= '0;
            state   <= S_FRAME;
          end
        end
        S_FRAME: begin
          if (div == DIV_LAST) begin
            div     <= '0;
            shift_q <= {1'b1, shift_q[FW-1:1]};
            if (bit_cnt == BC_LAST) begin
              idx    <= idx + 1'b1;
              word_q <= word_q >> 8;
              mask_q <= mask_q >> 1;
              state  <= S_NEXT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_uart_tx.sv
// Bench for sample_uart_tx: byte-level scoreboard fed by a word model, line decoded by a tx monitor.
module tb_sample_uart_tx;

`ifdef SAMPLE_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int BL = 10;
  localparam int FB = 10 + PAR;
  localparam int FL = BL * FB;
  localparam logic [31:0] ID_W = 32'h534c4131;

  logic        clock;
  logic        reset;
  logic [31:0] data;
  logic [3:0]  disabledGroups;
  logic        write, id, xon, xoff;
  logic        tx, busy, full, overflow;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rst_epoch = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  sample_uart_tx #(
    .FREQ(1000), .RATE(100), .BYTES(4), .FIFO_DEPTH(4), .STOP_BITS(1)
  ) dut (
    .clock(clock), .reset(reset), .data(data), .disabledGroups(disabledGroups),
    .write(write), .id(id), .xon(xon), .xoff(xoff),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: enabled bytes of a word leave LSB byte first
  task automatic expect_word(input logic [31:0] d, input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (!m[i]) exp_q.push_back(d[8*i +: 8]);
  endtask

  // drivers (called at a negedge; 'at' is the posedge count that sampled the strobe)
  task automatic drive_push(input logic [31:0] d, input logic [3:0] m,
                            input logic w, input logic i, output int at);
    data = d; disabledGroups = m; write = w; id = i;
    @(negedge clock);
    at = cyc;
    write = 1'b0; id = 1'b0;
  endtask

  task automatic pulse(input logic on_x, input logic off_x, output int at);
    xon = on_x; xoff = off_x;
    @(negedge clock);
    at = cyc;
    xon = 1'b0; xoff = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (start_q.size() < target && n < budget) begin @(negedge clock); n++; end
    check("start_wait", start_q.size() >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 6000) begin @(negedge clock); n++; end
    check({name, "_drain"}, n < 6000, 1);
    repeat (3) @(negedge clock);
  endtask

  // monitor: decodes frames off tx and scores them against exp_q
  initial begin : monitor
    logic       tx_prev;
    logic [7:0] b, eb;
    logic       fmt_ok, par_bit;
    int         ep;
    tx_prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset && tx_prev && !tx) begin
        start_q.push_back(cyc);
        ep = rst_epoch; fmt_ok = 1'b1; b = 8'h00; par_bit = 1'b0;
        for (int k = 0; k < FB; k++) begin
          repeat (k == 0 ? 5 : 10) @(negedge clock);
          if (rst_epoch != ep) break;
          if (k == 0) fmt_ok &= (tx == 1'b0);
          else if (k <= 8) b[k-1] = tx;
          else if (PAR == 1 && k == 9) par_bit = tx;
          else fmt_ok &= (tx == 1'b1);
        end
        if (rst_epoch == ep) begin
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else begin
            eb = exp_q.pop_front();
            check("byte", b, eb);
            check("frame_fmt", fmt_ok, 1);
`ifdef SAMPLE_UART_TX_PARITY_EN
            check("parity", par_bit, ^eb);
`endif
          end
        end
      end
      tx_prev = tx;
    end
  end

  initial begin : main
    int t, s0, base, nw;
    logic [31:0] d, w;
    logic [3:0]  m;
    reset = 1'b0; write = 1'b0; id = 1'b0; xon = 1'b0; xoff = 1'b0;
    data = '0; disabledGroups = '0;
    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // full word: latency, inter-frame gap, busy fall
    base = start_q.size();
    expect_word(32'hA5C30F81, 4'h0);
    drive_push(32'hA5C30F81, 4'h0, 1'b1, 1'b0, t);
    check("busy_rise", busy, 1);
    wait_starts(base + 4, 2 * FL * 4);
    check("latency", start_q[base] - t, 3);
    check("gap01", start_q[base+1] - start_q[base], FL + 1);
    check("gap23", start_q[base+3] - start_q[base+2], FL + 1);
    s0 = start_q[base+3];
    while (cyc < s0 + FL) @(negedge clock);
    check("busy_last_stop", busy, 1);
    @(negedge clock);
    check("busy_fall", busy, 0);
    wait_idle("basic");

    // partial mask and all-disabled word
    base = start_q.size();
    expect_word(32'hA5C30F81, 4'b0101);
    drive_push(32'hA5C30F81, 4'b0101, 1'b1, 1'b0, t);
    wait_idle("mask");
    check("mask_starts", start_q.size() - base, 2);

    base = start_q.size();
    drive_push(32'hA5C30F81, 4'hF, 1'b1, 1'b0, t);
    check("alldis_busy_rise", busy, 1);
    while (cyc < t + 6) @(negedge clock);
    check("alldis_busy_hold", busy, 1);
    @(negedge clock);
    check("alldis_busy_fall", busy, 0);
    check("alldis_tx", tx, 1);
    check("alldis_starts", start_q.size() - base, 0);

    // id word, then write+id collision
    expect_word(ID_W, 4'h0);
    drive_push(32'h0, 4'h0, 1'b0, 1'b1, t);
    wait_idle("id");
    w = $urandom;
    expect_word(w, 4'h0);
    drive_push(w, 4'h0, 1'b1, 1'b1, t);
    wait_idle("write_id");
    check("collide_no_ovf", overflow, 0);

    // xoff mid-word, xon resume, xon+xoff together
    base = start_q.size();
    expect_word(32'h3C5A96E1, 4'h0);
    drive_push(32'h3C5A96E1, 4'h0, 1'b1, 1'b0, t);
    wait_starts(base + 2, 400);
    repeat (20) @(negedge clock);
    pulse(1'b0, 1'b1, t);
    repeat (500) @(negedge clock);
    check("pause_hold", start_q.size() - base, 2);
    check("pause_tx", tx, 1);
    check("pause_busy", busy, 1);
    pulse(1'b1, 1'b0, t);
    wait_starts(base + 3, 50);
    check("resume_latency", start_q[base+2] - t, 1);
    wait_idle("pause");
    pulse(1'b1, 1'b1, t);
    base = start_q.size();
    w = $urandom;
    expect_word(w, 4'h0);
    drive_push(w, 4'h0, 1'b1, 1'b0, t);
    wait_starts(base + 1, 50);
    check("xonxoff_latency", start_q[base] - t, 3);
    wait_idle("xonxoff");

    // FIFO overflow while sending
    w = $urandom;
    expect_word(w, 4'h0);
    drive_push(w, 4'h0, 1'b1, 1'b0, t);
    repeat (3) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      if (i < 4) expect_word(w, 4'h0);
      data = w; disabledGroups = 4'h0; write = 1'b1;
      @(negedge clock);
      if (i == 2) check("full_at3", full, 0);
      if (i == 3) begin
        check("full_at4", full, 1);
        check("ovf_at4", overflow, 0);
      end
    end
    write = 1'b0;
    check("overflow_set", overflow, 1);
    wait_idle("overflow");
    check("ovf_sticky", overflow, 1);
    check("full_clear", full, 0);

    // reset in the middle of data bit 5 of byte 2
    base = start_q.size();
    expect_word(32'h5A003C11, 4'h0);
    drive_push(32'h5A003C11, 4'h0, 1'b1, 1'b0, t);
    wait_starts(base + 3, 600);
    s0 = start_q[base+2];
    while (cyc < s0 + 65) @(negedge clock);
    check("pre_rst_tx", tx, 0);
    #2;
    reset = 1'b0; rst_epoch++; exp_q.delete();
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow, 0);
    check("midrst_full", full, 0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    repeat (120) @(negedge clock);
    check("post_rst_quiet", start_q.size() - base, 3);
    base = start_q.size();
    w = $urandom;
    expect_word(w, 4'h0);
    drive_push(w, 4'h0, 1'b1, 1'b0, t);
    wait_starts(base + 1, 50);
    check("post_rst_latency", start_q[base] - t, 3);
    wait_idle("post_rst");

    // two 8'h07 bytes: frame length (and parity bit when enabled)
    base = start_q.size();
    expect_word(32'h00000707, 4'b1100);
    drive_push(32'h00000707, 4'b1100, 1'b1, 1'b0, t);
    wait_starts(base + 2, 400);
    check("frame_len", start_q[base+1] - start_q[base], FL + 1);
    wait_idle("parity");

    // randomized bursts
    for (int r = 0; r < 5; r++) begin
      nw = $urandom_range(1, 3);
      for (int j = 0; j < nw; j++) begin
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) begin
          expect_word(ID_W, 4'h0);
          drive_push(d, m, 1'b0, 1'b1, t);
        end else begin
          expect_word(d, m);
          drive_push(d, m, 1'b1, 1'b0, t);
        end
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
      wait_idle("rand");
    end
    check("rand_no_ovf", overflow, 0);
    check("final_tx", tx, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
